// File: rtl/skolem_pkg.sv
// rtl/skolem_pkg.sv - shared enums and state encodings for the Skolem witness search engine
package skolem_pkg;

  typedef enum logic [1:0] {
    OP_IDENT = 2'd0,
    OP_NEG   = 2'd1,
    OP_NOT   = 2'd2,
    OP_RSVD  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    PRED_SLE = 2'd0,
    PRED_SLT = 2'd1,
    PRED_ULE = 2'd2,
    PRED_ULT = 2'd3
  } pred_e;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SEARCH = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    SEARCH = ST_SEARCH,
    RESP   = ST_RESP
  } state_e;

endpackage

// File: rtl/skolem_pred_eval.sv
// rtl/skolem_pred_eval.sv - combinational check of pred(op(x), t) in W-bit arithmetic
module skolem_pred_eval
  import skolem_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] t,
  input  logic [1:0]   op,
  input  logic [1:0]   pred,
  output logic         match
);

  logic [W-1:0] y;

  // The reserved op encoding falls through to identity.
  always_comb begin
    y = x;
    case (op_e'(op))
      OP_NEG:  y = -x;
      OP_NOT:  y = ~x;
      default: y = x;
    endcase
  end

  always_comb begin
    match = 1'b0;
    case (pred_e'(pred))
      PRED_SLE: match = ($signed(y) <= $signed(t));
      PRED_SLT: match = ($signed(y) <  $signed(t));
      PRED_ULE: match = (y <= t);
      PRED_ULT: match = (y <  t);
      default:  match = 1'b0;
    endcase
  end

endmodule

// File: rtl/skolem_inv_search.sv
// rtl/skolem_inv_search.sv - sequential wrap-around witness search for invertibility conditions
module skolem_inv_search
  import skolem_pkg::*;
#(
  parameter int W     = 4,
  parameter int CNT_W = W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [W-1:0]     req_t,
  input  logic [W-1:0]     req_start,
  input  logic [1:0]       req_op,
  input  logic [1:0]       req_pred,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [W-1:0]     resp_x,
  output logic             resp_found,
  output logic [CNT_W-1:0] resp_iters
);

  localparam logic [CNT_W-1:0] ITERS_FULL = CNT_W'(1) << W;

  state_e           state;
  logic [W-1:0]     t_q;
  logic [1:0]       op_q;
  logic [1:0]       pred_q;
  logic [W-1:0]     cand;
  logic [CNT_W-1:0] iters;
  logic [CNT_W-1:0] iters_nxt;
  logic             match;

  assign iters_nxt = iters + CNT_W'(1);

  skolem_pred_eval #(.W(W)) u_pred_eval (
    .x     (cand),
    .t     (t_q),
    .op    (op_q),
    .pred  (pred_q),
    .match (match)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_x     <= '0;
      resp_found <= 1'b0;
      resp_iters <= '0;
      t_q        <= '0;
      op_q       <= '0;
      pred_q     <= '0;
      cand       <= '0;
      iters      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            t_q       <= req_t;
            op_q      <= req_op;
            pred_q    <= req_pred;
            cand      <= req_start;
            iters     <= '0;
            req_ready <= 1'b0;
            state     <= SEARCH;
          end
        end
        SEARCH: begin
          iters <= iters_nxt;
          if (match) begin
            resp_x     <= cand;
            resp_found <= 1'b1;
            resp_iters <= iters_nxt;
            resp_valid <= 1'b1;
            state      <= RESP;
          end else if (iters_nxt == ITERS_FULL) begin
            resp_x     <= '0;
            resp_found <= 1'b0;
            resp_iters <= iters_nxt;
            resp_valid <= 1'b1;
            state      <= RESP;
          end else begin
            cand <= cand + W'(1);
          end
        end
        RESP: begin
          // resp_ready is only looked at here, so a result always shows for a cycle.
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_skolem_inv_search.sv
// tb/tb_skolem_inv_search.sv - randomized self-checking bench with arithmetic reference model
module tb_skolem_inv_search;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_t;
  logic [3:0] req_start;
  logic [1:0] req_op;
  logic [1:0] req_pred;
  logic       resp_valid;
  logic       resp_ready;
  logic [3:0] resp_x;
  logic       resp_found;
  logic [4:0] resp_iters;

  int n_checks;
  int n_pass;

  skolem_inv_search #(.W(4), .CNT_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_t      (req_t),
    .req_start  (req_start),
    .req_op     (req_op),
    .req_pred   (req_pred),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_x     (resp_x),
    .resp_found (resp_found),
    .resp_iters (resp_iters)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: walk candidates from start in wrap order, evaluating the predicate on integers.
  function automatic void model(input int t, input int start, input int op, input int pred,
                                output int x, output int found, output int iters);
    int c, y, sy, st;
    bit m;
    x = 0; found = 0; iters = 16;
    for (int k = 0; k < 16; k++) begin
      c = (start + k) % 16;
      if (op == 1)      y = (16 - c) % 16;
      else if (op == 2) y = 15 - c;
      else              y = c;
      sy = (y >= 8) ? y - 16 : y;
      st = (t >= 8) ? t - 16 : t;
      case (pred)
        0:       m = (sy <= st);
        1:       m = (sy <  st);
        2:       m = (y <= t);
        default: m = (y <  t);
      endcase
      if (m) begin
        x = c; found = 1; iters = k + 1;
        return;
      end
    end
  endfunction

  task automatic start_req(input logic [3:0] t, input logic [3:0] s, input logic [1:0] op,
                           input logic [1:0] pred, output int lat);
    int w;
    w = 0;
    @(negedge clk);
    while (!req_ready && w < 40) begin
      @(negedge clk);
      w++;
    end
    req_valid = 1'b1; req_t = t; req_start = s; req_op = op; req_pred = pred;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!resp_valid) lat = 99;
  endtask

  task automatic release_resp();
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready got %0b want 1", req_ready); else n_pass++;
    n_checks++; if (resp_valid !== 1'b0) $display("FAIL reset_resp_valid got %0b want 0", resp_valid); else n_pass++;
    n_checks++; if ({resp_x, resp_found, resp_iters} !== 10'd0)
      $display("FAIL reset_resp got x=%0h f=%0b i=%0d want 0", resp_x, resp_found, resp_iters); else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [3:0] tv[4] = '{4'h0, 4'h8, 4'h8, 4'h1};
    logic [3:0] sv[4] = '{4'h0, 4'h0, 4'h0, 4'hF};
    logic [1:0] ov[4] = '{2'd1, 2'd1, 2'd1, 2'd0};
    logic [1:0] pv[4] = '{2'd0, 2'd1, 2'd0, 2'd2};
    int ex[4] = '{0, 0, 8, 0};
    int ef[4] = '{1, 0, 1, 1};
    int ei[4] = '{1, 16, 9, 2};
    int lat;
    for (int i = 0; i < 4; i++) begin
      start_req(tv[i], sv[i], ov[i], pv[i], lat);
      @(negedge clk);
      n_checks++; if (lat != ei[i]) $display("FAIL dir%0d_latency got %0d want %0d", i, lat, ei[i]); else n_pass++;
      n_checks++; if (resp_x !== 4'(ex[i]) || resp_found !== 1'(ef[i]) || resp_iters !== 5'(ei[i]))
        $display("FAIL dir%0d_resp got x=%0h f=%0b i=%0d want x=%0h f=%0d i=%0d",
                 i, resp_x, resp_found, resp_iters, ex[i], ef[i], ei[i]); else n_pass++;
      release_resp();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    start_req(4'h8, 4'h0, 2'd1, 2'd0, lat);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++; if (resp_valid !== 1'b1 || req_ready !== 1'b0 || resp_x !== 4'h8 || resp_found !== 1'b1 || resp_iters !== 5'd9)
        $display("FAIL bp_hold%0d got v=%0b rr=%0b x=%0h f=%0b i=%0d want v=1 rr=0 x=8 f=1 i=9",
                 c, resp_valid, req_ready, resp_x, resp_found, resp_iters); else n_pass++;
    end
    release_resp();
    n_checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL bp_release got v=%0b rr=%0b want v=0 rr=1", resp_valid, req_ready); else n_pass++;
  endtask

  task automatic test_reset_mid_search();
    int lat;
    @(negedge clk);
    req_valid = 1'b1; req_t = 4'h8; req_start = 4'h0; req_op = 2'd1; req_pred = 2'd1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    n_checks++; if (req_ready !== 1'b0) $display("FAIL mid_busy got rr=%0b want 0", req_ready); else n_pass++;
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1 || resp_x !== 4'h0 || resp_iters !== 5'd0)
      $display("FAIL mid_async_reset got v=%0b rr=%0b x=%0h i=%0d want v=0 rr=1 x=0 i=0",
               resp_valid, req_ready, resp_x, resp_iters); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    start_req(4'h0, 4'h0, 2'd1, 2'd0, lat);
    @(negedge clk);
    n_checks++; if (lat != 1 || resp_x !== 4'h0 || resp_found !== 1'b1 || resp_iters !== 5'd1)
      $display("FAIL mid_after got lat=%0d x=%0h f=%0b i=%0d want lat=1 x=0 f=1 i=1",
               lat, resp_x, resp_found, resp_iters); else n_pass++;
    release_resp();
  endtask

  task automatic test_ignore_busy();
    int w;
    @(negedge clk);
    req_valid = 1'b1; req_t = 4'h1; req_start = 4'hF; req_op = 2'd3; req_pred = 2'd2;
    @(posedge clk);
    #1;
    req_t = 4'h8; req_start = 4'h3; req_op = 2'd1; req_pred = 2'd1;
    w = 0;
    while (!resp_valid && w < 40) begin
      @(posedge clk);
      #1;
      w++;
    end
    req_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (w != 2 || resp_x !== 4'h0 || resp_found !== 1'b1 || resp_iters !== 5'd2)
      $display("FAIL ignore_busy got lat=%0d x=%0h f=%0b i=%0d want lat=2 x=0 f=1 i=2",
               w, resp_x, resp_found, resp_iters); else n_pass++;
    release_resp();
  endtask

  task automatic test_back_to_back();
    int lat, ex, ef, ei;
    logic [3:0] t, s;
    logic [1:0] op, pr;
    for (int i = 0; i < 4; i++) begin
      t = 4'($urandom); s = 4'($urandom); op = 2'($urandom); pr = 2'($urandom);
      model(int'(t), int'(s), int'(op), int'(pr), ex, ef, ei);
      start_req(t, s, op, pr, lat);
      n_checks++; if (lat != ei || resp_x !== 4'(ex) || resp_found !== 1'(ef) || resp_iters !== 5'(ei))
        $display("FAIL b2b%0d got lat=%0d x=%0h f=%0b i=%0d want lat=%0d x=%0h f=%0d i=%0d",
                 i, lat, resp_x, resp_found, resp_iters, ei, ex, ef, ei); else n_pass++;
      release_resp();
    end
  endtask

  task automatic test_random();
    int lat, ex, ef, ei, d;
    logic [3:0] t, s;
    logic [1:0] op, pr;
    for (int i = 0; i < 300; i++) begin
      t = 4'($urandom); s = 4'($urandom); op = 2'($urandom); pr = 2'($urandom);
      model(int'(t), int'(s), int'(op), int'(pr), ex, ef, ei);
      start_req(t, s, op, pr, lat);
      d = $urandom_range(0, 3);
      repeat (d + 1) @(negedge clk);
      n_checks++; if (lat != ei) $display("FAIL rand%0d_latency t=%0h s=%0h op=%0d p=%0d got %0d want %0d",
                                          i, t, s, op, pr, lat, ei); else n_pass++;
      n_checks++; if (resp_valid !== 1'b1 || resp_x !== 4'(ex) || resp_found !== 1'(ef) || resp_iters !== 5'(ei))
        $display("FAIL rand%0d_resp t=%0h s=%0h op=%0d p=%0d got v=%0b x=%0h f=%0b i=%0d want x=%0h f=%0d i=%0d",
                 i, t, s, op, pr, resp_valid, resp_x, resp_found, resp_iters, ex, ef, ei); else n_pass++;
      release_resp();
    end
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    rst_n = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
    req_t = '0; req_start = '0; req_op = '0; req_pred = '0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_search();
    test_ignore_busy();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
